pll_lock_sequencer: RTL and testbench

- Sequences the board PLL, which takes a 50 MHz reference and produces 50 MHz and 100 MHz outputs.
- Drives the PLL reset pulse, synchronises and debounces the PLL `locked` flag, and enforces a lock timeout with bounded retries.
- Releases the reset used by downstream channel-coding/QPSK logic only after lock has been stable for a programmed time.
- Runs on the PLL reference clock, so it keeps operating while the PLL is unlocked.

---
 rtl/pll_lock_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock flag,
// retries on timeout and releases the downstream datapath reset only after stable lock.
module pll_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 17
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       force_relock,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic       loss_of_lock,
   output logic [3:0] retry_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABILIZE = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRIES - 1);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       lk_sync;
   logic             lk;

   assign lk    = lk_sync[1];
   assign state = st;

   // Output pattern {pll_rst, sys_rst_n, ready, fault} for the state being entered.
   function automatic logic [3:0] outs_for(state_t s);
      case (s)
         S_RESET_PLL: outs_for = 4'b1000;
         S_RUN:       outs_for = 4'b0110;
         S_FAULT:     outs_for = 4'b1001;
         default:     outs_for = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge refclk) begin
      if (!rst) begin
         lk_sync      <= 2'b00;
         st           <= S_RESET_PLL;
         cnt          <= '0;
         retry_count  <= 4'd0;
         pll_rst      <= 1'b1;
         sys_rst_n    <= 1'b0;
         ready        <= 1'b0;
         fault        <= 1'b0;
         loss_of_lock <= 1'b0;
      end else begin
         lk_sync      <= {lk_sync[0], pll_locked};
         loss_of_lock <= 1'b0;
         case (st)
            S_RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  st  <= S_WAIT_LOCK;
                  cnt <= '0;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_WAIT_LOCK);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               // Lock seen on the timeout cycle still wins over the retry.
               if (lk) begin
                  st  <= S_STABILIZE;
                  cnt <= '0;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_STABILIZE);
               end else if (cnt == TO_LAST) begin
                  cnt <= '0;
                  if (retry_count == RETRY_LAST) begin
                     st          <= S_FAULT;
                     retry_count <= RETRY_MAX;
                     {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_FAULT);
                  end else begin
                     st          <= S_RESET_PLL;
                     retry_count <= retry_count + 4'd1;
                     {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_RESET_PLL);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STABILIZE: begin
               if (!lk) begin
                  st  <= S_WAIT_LOCK;
                  cnt <= '0;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_WAIT_LOCK);
               end else if (cnt == STAB_LAST) begin
                  st          <= S_RUN;
                  cnt         <= '0;
                  retry_count <= 4'd0;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_RUN);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               cnt <= '0;
               if (!lk || force_relock) begin
                  st           <= S_RESET_PLL;
                  loss_of_lock <= !lk;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_RESET_PLL);
               end
            end
            S_FAULT: begin
               cnt <= '0;
               if (force_relock) begin
                  st          <= S_RESET_PLL;
                  retry_count <= 4'd0;
                  {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_RESET_PLL);
               end
            end
            default: begin
               st  <= S_RESET_PLL;
               cnt <= '0;
               {pll_rst, sys_rst_n, ready, fault} <= outs_for(S_RESET_PLL);
            end
         endcase
      end
   end

   // The shared counter must reach every limit without wrapping.
   always_ff @(posedge refclk) begin : param_check
      assert (RST_PULSE_CYCLES >= 2 && LOCK_STABLE_CYCLES >= 2 && LOCK_TIMEOUT_CYCLES >= 1 &&
              MAX_RETRIES >= 1 && MAX_RETRIES <= 15 &&
              longint'(RST_PULSE_CYCLES)    < (longint'(1) << CNT_W) &&
              longint'(LOCK_STABLE_CYCLES)  < (longint'(1) << CNT_W) &&
              longint'(LOCK_TIMEOUT_CYCLES) < (longint'(1) << CNT_W))
         else $error("pll_lock_sequencer: illegal parameter set");
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboarded bench for pll_lock_sequencer: directed scenarios plus random lock
// activity, checked every cycle against a rule-level reference model.
module tb_pll_lock_sequencer;

   localparam int T_RST  = 4;
   localparam int T_STAB = 8;
   localparam int T_TO   = 32;
   localparam int T_MAX  = 2;

   logic       refclk = 1'b0;
   logic       rst, pll_locked, force_relock;
   logic       pll_rst, sys_rst_n, ready, fault, loss_of_lock;
   logic [3:0] retry_count;
   logic [2:0] state;

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES(T_RST), .LOCK_STABLE_CYCLES(T_STAB),
      .LOCK_TIMEOUT_CYCLES(T_TO), .MAX_RETRIES(T_MAX), .CNT_W(17)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
      .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
      .loss_of_lock(loss_of_lock), .retry_count(retry_count), .state(state)
   );

   always #5 refclk = ~refclk;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] rc;
      logic       pr, sr, rdy, flt, lol;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   saw_run, saw_fault, saw_lol;

   // Reference model: phase numbers follow the published state encoding,
   // lock history is the raw input delayed by two samples.
   int m_phase, m_spent, m_fails;
   bit m_h0, m_h1, m_lol;

   function automatic void model_step(input logic r, input logic pl, input logic fr);
      bit lk_now;
      int nxt;
      if (!r) begin
         m_phase = 0; m_spent = 0; m_fails = 0; m_h0 = 0; m_h1 = 0; m_lol = 0;
         return;
      end
      lk_now = m_h1;
      m_h1   = m_h0;
      m_h0   = pl;
      m_lol  = 0;
      nxt    = m_phase;
      case (m_phase)
         0: if (m_spent + 1 == T_RST) nxt = 1;
         1: begin
            if (lk_now) nxt = 2;
            else if (m_spent + 1 == T_TO) begin
               if (m_fails + 1 == T_MAX) begin nxt = 4; m_fails = T_MAX; end
               else begin nxt = 0; m_fails = m_fails + 1; end
            end
         end
         2: begin
            if (!lk_now) nxt = 1;
            else if (m_spent + 1 == T_STAB) begin nxt = 3; m_fails = 0; end
         end
         3: begin
            if (!lk_now) begin nxt = 0; m_lol = 1; end
            else if (fr) nxt = 0;
         end
         default: if (fr) begin nxt = 0; m_fails = 0; end
      endcase
      m_spent = (nxt != m_phase) ? 0 : m_spent + 1;
      m_phase = nxt;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.st  = 3'(m_phase);
      o.rc  = 4'(m_fails);
      o.pr  = (m_phase == 0) || (m_phase == 4);
      o.sr  = (m_phase == 3);
      o.rdy = (m_phase == 3);
      o.flt = (m_phase == 4);
      o.lol = m_lol;
      return o;
   endfunction

   // One clock: inputs held across the edge, expectation queued just after it.
   task automatic tick(input logic r, input logic pl, input logic fr);
      rst = r; pll_locked = pl; force_relock = fr;
      @(posedge refclk);
      #1;
      model_step(r, pl, fr);
      exp_q.push_back(model_obs());
   endtask

   task automatic wait_phase(input int p, input logic pl, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (m_phase == p) return;
         tick(1'b1, pl, 1'b0);
      end
      checks++;
      errors++;
      $display("FAIL %s: phase %0d not reached within %0d cycles (model phase %0d)", name, p, budget, m_phase);
   endtask

   // Monitor: every cycle the DUT presents its registered outputs.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge refclk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state, rc: retry_count, pr: pll_rst, sr: sys_rst_n,
                  rdy: ready, flt: fault, lol: loss_of_lock};
            if (a.st == 3'd3) saw_run = 1;
            if (a.st == 3'd4) saw_fault = 1;
            if (a.lol) saw_lol = 1;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got st=%0d rc=%0d pr=%b sr=%b rdy=%b flt=%b lol=%b want st=%0d rc=%0d pr=%b sr=%b rdy=%b flt=%b lol=%b",
                        cyc, a.st, a.rc, a.pr, a.sr, a.rdy, a.flt, a.lol,
                        e.st, e.rc, e.pr, e.sr, e.rdy, e.flt, e.lol);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic cur_pl;
      int   hold;
      rst = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;

      // Clean lock after reset
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      repeat (10) tick(1'b1, 1'b0, 1'b0);
      wait_phase(3, 1'b1, 60, "clean_lock");
      repeat (5) tick(1'b1, 1'b1, 1'b0);

      // Loss of lock in RUN, random dropout width, then re-lock
      repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0, 1'b0);
      wait_phase(3, 1'b1, 80, "relock_after_loss");
      repeat (3) tick(1'b1, 1'b1, 1'b0);

      // force_relock coinciding with lk falling
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      wait_phase(3, 1'b1, 80, "relock_after_simultaneous");

      // Plain force_relock in RUN
      tick(1'b1, 1'b1, 1'b1);
      wait_phase(2, 1'b1, 40, "reach_stabilize");
      repeat (4) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      wait_phase(3, 1'b1, 80, "relock_after_glitch");

      // Timeouts to FAULT, with force_relock ignored in WAIT_LOCK and RESET_PLL
      tick(1'b1, 1'b0, 1'b0);
      wait_phase(1, 1'b0, 20, "reach_wait_lock");
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      wait_phase(4, 1'b0, 120, "reach_fault");
      repeat (5) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      repeat (2) tick(1'b1, 1'b0, 1'b1);
      repeat (3) tick(1'b1, 1'b1, 1'b0);

      // Reset mid-STABILIZE
      wait_phase(2, 1'b1, 60, "reach_stabilize_2");
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      wait_phase(3, 1'b1, 60, "relock_after_reset");

      // Random lock activity with occasional relock requests and resets
      cur_pl = 1'b1;
      hold   = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            cur_pl = 1'($urandom_range(0, 1));
            hold   = cur_pl ? $urandom_range(1, 40) : (($urandom_range(0, 7) == 0) ? $urandom_range(30, 90) : $urandom_range(1, 6));
         end
         hold--;
         tick(($urandom_range(0, 199) != 0), cur_pl, ($urandom_range(0, 19) == 0));
      end

      @(negedge refclk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      checks++;
      if (!saw_run) begin errors++; $display("FAIL reach_run: saw_run=%0d want 1", saw_run); end
      checks++;
      if (!saw_fault) begin errors++; $display("FAIL reach_fault_obs: saw_fault=%0d want 1", saw_fault); end
      checks++;
      if (!saw_lol) begin errors++; $display("FAIL lol_seen: saw_lol=%0d want 1", saw_lol); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
